// File: rtl/alarm_ctrl.sv
// alarm_ctrl: sequencing controller for the alarm register/compare block.
// Edits the four mm:ss alarm digits from one-pulse buttons, commits them with
// a one-cycle load strobe, arms/disarms the alarm and runs the ringing
// sequence (acknowledge, timeout and optional snooze).
// Optional feature macro: ALARM_SNOOZE_EN (compiles in the SNOOZE state and
// the btn_inc snooze path while ringing; SNOOZE_SEC is otherwise unused).
// All buttons are single-cycle pulses; there is no handshake, and a pulse in
// cycle N is reflected on the registered outputs in cycle N+1.
module alarm_ctrl #(
  parameter int RING_TIMEOUT  = 30,
  parameter int SNOOZE_SEC    = 60,
  parameter int BCD_BIT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick_1hz,
  input  logic                     btn_set,
  input  logic                     btn_inc,
  input  logic                     btn_ack,
  input  logic                     btn_arm,
  input  logic                     match,
  output logic                     load_value_enable,
  output logic [BCD_BIT_WIDTH-1:0] load_value_min1,
  output logic [BCD_BIT_WIDTH-1:0] load_value_min0,
  output logic [BCD_BIT_WIDTH-1:0] load_value_sec1,
  output logic [BCD_BIT_WIDTH-1:0] load_value_sec0,
  output logic                     alarm_enable,
  output logic                     ring,
  output logic [3:0]               edit_digit
);

  typedef logic [BCD_BIT_WIDTH-1:0] bcd_t;

  typedef enum logic [2:0] {
    IDLE, EDIT_M1, EDIT_M0, EDIT_S1, EDIT_S0, LOAD, RING
`ifdef ALARM_SNOOZE_EN
    , SNOOZE
`endif
  } state_t;

  localparam logic [7:0] RING_LIM = 8'(RING_TIMEOUT);
`ifdef ALARM_SNOOZE_EN
  localparam logic [7:0] SNOOZE_LIM = 8'(SNOOZE_SEC);
`endif

  // Elaboration-time guard on the legal parameter ranges.
  if (RING_TIMEOUT < 1 || RING_TIMEOUT > 255) begin : g_bad_ring_timeout
    $error("alarm_ctrl: RING_TIMEOUT must be 1..255");
  end
  if (SNOOZE_SEC < 1 || SNOOZE_SEC > 255) begin : g_bad_snooze_sec
    $error("alarm_ctrl: SNOOZE_SEC must be 1..255");
  end

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] cnt_inc;
  bcd_t       m1_n, m0_n, s1_n, s0_n;
  logic       arm_n;
  logic       match_q;
  logic       match_rise;

  // Digit increment with wrap; anything at or above the top value wraps to 0.
  function automatic bcd_t bump(input bcd_t d, input bcd_t top);
    return (d >= top) ? bcd_t'(0) : bcd_t'(d + bcd_t'(1));
  endfunction

  assign cnt_inc    = cnt + 8'd1;
  assign match_rise = match & ~match_q;

  // Next-state, counter, edit buffer and arm flag; ack > set > inc.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    m1_n    = load_value_min1;
    m0_n    = load_value_min0;
    s1_n    = load_value_sec1;
    s0_n    = load_value_sec0;
    arm_n   = alarm_enable;
    case (state)
      IDLE: begin
        if (btn_arm) arm_n = ~alarm_enable;
        // A match edge only counts here; edges seen in other states are lost.
        if (match_rise && alarm_enable) begin
          state_n = RING;
          cnt_n   = 8'd0;
        end else if (btn_set) begin
          state_n = EDIT_M1;
        end
      end
      EDIT_M1: begin
        if (btn_ack)      state_n = IDLE;
        else if (btn_set) state_n = EDIT_M0;
        else if (btn_inc) m1_n = bump(load_value_min1, bcd_t'(5));
      end
      EDIT_M0: begin
        if (btn_ack)      state_n = IDLE;
        else if (btn_set) state_n = EDIT_S1;
        else if (btn_inc) m0_n = bump(load_value_min0, bcd_t'(9));
      end
      EDIT_S1: begin
        if (btn_ack)      state_n = IDLE;
        else if (btn_set) state_n = EDIT_S0;
        else if (btn_inc) s1_n = bump(load_value_sec1, bcd_t'(5));
      end
      EDIT_S0: begin
        if (btn_ack)      state_n = IDLE;
        else if (btn_set) state_n = LOAD;
        else if (btn_inc) s0_n = bump(load_value_sec0, bcd_t'(9));
      end
      LOAD: state_n = IDLE;
      RING: begin
        if (btn_ack) begin
          state_n = IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (btn_inc) begin
          state_n = SNOOZE;
          cnt_n   = 8'd0;
`endif
        end else if (tick_1hz) begin
          cnt_n = cnt_inc;
          if (cnt_inc == RING_LIM) state_n = IDLE;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (btn_ack) begin
          state_n = IDLE;
        end else if (tick_1hz) begin
          if (cnt_inc == SNOOZE_LIM) begin
            state_n = RING;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // State, counter, buffer, arm flag and match history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      match_q         <= 1'b0;
      alarm_enable    <= 1'b0;
      load_value_min1 <= '0;
      load_value_min0 <= '0;
      load_value_sec1 <= '0;
      load_value_sec0 <= '0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      match_q         <= match;
      alarm_enable    <= arm_n;
      load_value_min1 <= m1_n;
      load_value_min0 <= m0_n;
      load_value_sec1 <= s1_n;
      load_value_sec0 <= s0_n;
    end
  end

  assign load_value_enable = (state == LOAD);
  assign ring              = (state == RING);

  // One-hot edit cursor decoded from the registered state.
  always_comb begin
    edit_digit = 4'b0000;
    case (state)
      EDIT_M1: edit_digit = 4'b1000;
      EDIT_M0: edit_digit = 4'b0100;
      EDIT_S1: edit_digit = 4'b0010;
      EDIT_S0: edit_digit = 4'b0001;
      default: edit_digit = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed bench for alarm_ctrl with RING_TIMEOUT=3 and
// SNOOZE_SEC=2. Snooze steps are included when ALARM_SNOOZE_EN is defined.
module tb_alarm_ctrl;

  localparam logic [4:0] T = 5'b10000;  // tick_1hz
  localparam logic [4:0] S = 5'b01000;  // btn_set
  localparam logic [4:0] I = 5'b00100;  // btn_inc
  localparam logic [4:0] A = 5'b00010;  // btn_ack
  localparam logic [4:0] R = 5'b00001;  // btn_arm
  localparam logic [4:0] N = 5'b00000;  // idle cycle

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, btn_set, btn_inc, btn_ack, btn_arm, match;
  logic       load_value_enable, alarm_enable, ring;
  logic [3:0] load_value_min1, load_value_min0, load_value_sec1, load_value_sec0;
  logic [3:0] edit_digit;

  int n_assert = 0;
  int n_fail   = 0;
  int strobes  = 0;

  alarm_ctrl #(.RING_TIMEOUT(3), .SNOOZE_SEC(2), .BCD_BIT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .btn_set(btn_set),
    .btn_inc(btn_inc), .btn_ack(btn_ack), .btn_arm(btn_arm), .match(match),
    .load_value_enable(load_value_enable),
    .load_value_min1(load_value_min1), .load_value_min0(load_value_min0),
    .load_value_sec1(load_value_sec1), .load_value_sec0(load_value_sec0),
    .alarm_enable(alarm_enable), .ring(ring), .edit_digit(edit_digit)
  );

  // Clock.
  always #5 clk = ~clk;

  // Count commit strobes seen at clock edges.
  always @(posedge clk) if (load_value_enable === 1'b1) strobes <= strobes + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_buf(input string tag, input logic [15:0] exp);
    chk(tag, {load_value_min1, load_value_min0, load_value_sec1, load_value_sec0}, exp);
  endtask

  // One clock with the given button/tick pulses, then release them.
  task automatic cyc(input logic [4:0] v);
    {tick_1hz, btn_set, btn_inc, btn_ack, btn_arm} = v;
    @(posedge clk);
    #1;
    {tick_1hz, btn_set, btn_inc, btn_ack, btn_arm} = N;
  endtask

  initial begin
    rst_n = 1'b0;
    match = 1'b0;
    {tick_1hz, btn_set, btn_inc, btn_ack, btn_arm} = N;
    repeat (2) @(posedge clk);
    #1;
    chk_buf("rst_buf", 16'h0000);
    chk("rst_load_en", load_value_enable, 1'b0);
    chk("rst_arm", alarm_enable, 1'b0);
    chk("rst_ring", ring, 1'b0);
    chk("rst_edit", edit_digit, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full edit and commit: 32:05.
    cyc(S);
    chk("edit_m1", edit_digit, 4'b1000);
    repeat (3) cyc(I);
    chk_buf("m1_is_3", 16'h3000);
    cyc(S);
    chk("edit_m0", edit_digit, 4'b0100);
    repeat (12) cyc(I);
    chk_buf("m0_wrap_2", 16'h3200);
    cyc(S);
    cyc(S);
    chk("edit_s0", edit_digit, 4'b0001);
    repeat (5) cyc(I);
    cyc(S);
    chk("commit_strobe", load_value_enable, 1'b1);
    chk_buf("commit_value", 16'h3205);
    chk("commit_edit", edit_digit, 4'b0000);
    cyc(N);
    chk("strobe_one_cycle", load_value_enable, 1'b0);
    chk("strobe_count_1", 16'(strobes), 16'd1);

    // Re-edit from stored buffer, min1 wrap, abort from EDIT_S1.
    cyc(S);
    repeat (3) cyc(I);
    chk_buf("m1_wrap_0", 16'h0205);
    cyc(S);
    cyc(S);
    chk("edit_s1", edit_digit, 4'b0010);
    match = 1'b1;  // edge while editing is discarded
    repeat (7) cyc(I);
    cyc(R);        // arm ignored outside IDLE
    cyc(A);
    chk("abort_edit", edit_digit, 4'b0000);
    chk_buf("abort_keeps_buf", 16'h0215);
    chk("arm_ignored_edit", alarm_enable, 1'b0);
    chk("edit_edge_lost", ring, 1'b0);
    chk("abort_no_strobe", 16'(strobes), 16'd1);

    // Match handling with arm.
    match = 1'b0;
    cyc(N);
    match = 1'b1;
    cyc(N);
    chk("disarmed_no_ring", ring, 1'b0);
    cyc(R);
    chk("arm_on", alarm_enable, 1'b1);
    chk("held_match_no_ring", ring, 1'b0);
    cyc(N);
    chk("held_match_no_ring2", ring, 1'b0);
    match = 1'b0;
    cyc(N);
    match = 1'b1;
    cyc(N);
    chk("edge_rings", ring, 1'b1);

`ifdef ALARM_SNOOZE_EN
    cyc(I);
    chk("snooze_quiet", ring, 1'b0);
    cyc(T);
    chk("snooze_tick1", ring, 1'b0);
    cyc(T);
    chk("snooze_rering", ring, 1'b1);
    cyc(A);
    chk("snooze_ack", ring, 1'b0);
    match = 1'b0;
    cyc(N);
    match = 1'b1;
    cyc(N);
    chk("edge_rings_again", ring, 1'b1);
`else
    cyc(I);
    chk("inc_ignored_ring", ring, 1'b1);
`endif

    // Timeout after three ticks.
    cyc(T);
    chk("timeout_t1", ring, 1'b1);
    cyc(T);
    chk("timeout_t2", ring, 1'b1);
    cyc(T);
    chk("timeout_t3", ring, 1'b0);
    chk("arm_kept_timeout", alarm_enable, 1'b1);

    // Ack wins over a simultaneous tick; counter clears on the next ring.
    match = 1'b0;
    cyc(N);
    match = 1'b1;
    cyc(N);
    chk("ring_3", ring, 1'b1);
    cyc(T);
    cyc(T | A);
    chk("ack_beats_tick", ring, 1'b0);
    chk("arm_kept_ack", alarm_enable, 1'b1);
    match = 1'b0;
    cyc(N);
    match = 1'b1;
    cyc(N);
    cyc(T);
    cyc(T);
    chk("count_cleared", ring, 1'b1);
    cyc(T);
    chk("timeout_again", ring, 1'b0);
    cyc(R);
    chk("arm_off", alarm_enable, 1'b0);

    // Asynchronous reset mid-edit with a nonzero buffer.
    match = 1'b0;
    cyc(S);
    cyc(S);
    cyc(S);
    cyc(S);
    chk("pre_reset_s0", edit_digit, 4'b0001);
    chk_buf("pre_reset_buf", 16'h0215);
    #3;
    rst_n = 1'b0;
    #1;
    chk_buf("async_rst_buf", 16'h0000);
    chk("async_rst_edit", edit_digit, 4'b0000);
    chk("async_rst_load", load_value_enable, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(N);
    chk("post_rst_load", load_value_enable, 1'b0);
    chk("post_rst_strobes", 16'(strobes), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
